// File: rtl/toggle_stim_gen_pkg.sv
// Shared definitions for the toggle stimulus generator: default widths and FSM encoding.
package toggle_stim_gen_pkg;

  localparam int CNT_W_DEF = 8;
  localparam int RUN_W_DEF = 16;

  // 2'd3 is unused and recovers to ST_IDLE
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/toggle_stim_gen_toggler.sv
// One square-wave channel: toggles q every `half` enabled cycles; half==0 keeps q at 0.
module half_period_toggler
  import toggle_stim_gen_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [CNT_W-1:0] half,
  output logic             q
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             q_q, q_d;

  always_comb begin
    cnt_d = cnt_q;
    q_d   = q_q;
    if (clr) begin
      cnt_d = '0;
      q_d   = 1'b0;
    end else if (en && (half != '0)) begin
      if (cnt_q == half - CNT_W'(1)) begin
        cnt_d = '0;
        q_d   = ~q_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      q_q   <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      q_q   <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/toggle_stim_gen.sv
// Stimulus source for the 2:1 mux stage: three square-wave channels (sel, i0, i1)
// launched together and run for a latched number of cycles.
module toggle_stim_gen
  import toggle_stim_gen_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int RUN_W = RUN_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] half_sel,
  input  logic [CNT_W-1:0] half_i0,
  input  logic [CNT_W-1:0] half_i1,
  input  logic [RUN_W-1:0] run_len,
  output logic             sel,
  output logic             i0,
  output logic             i1,
  output logic             busy,
  output logic             done
);

  localparam int NCH = 3;

  state_e                        state_q, state_d;
  logic [RUN_W-1:0]              elapsed_q, elapsed_d;
  logic [RUN_W-1:0]              run_len_q, run_len_d;
  logic [NCH-1:0][CNT_W-1:0]     half_q, half_d;
  logic                          finish;
  logic                          tog_en, tog_clr;
  logic [NCH-1:0]                tog_q;

  assign finish = (state_q == ST_RUN) && (elapsed_q == run_len_q - RUN_W'(1));

  always_comb begin
    state_d   = state_q;
    elapsed_d = elapsed_q;
    run_len_d = run_len_q;
    half_d    = half_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          half_d    = {half_i1, half_i0, half_sel};
          run_len_d = run_len;
          elapsed_d = '0;
          state_d   = (run_len == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (finish) state_d = ST_DONE;
        else        elapsed_d = elapsed_q + RUN_W'(1);
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      elapsed_q <= '0;
      run_len_q <= '0;
      half_q    <= '0;
    end else begin
      state_q   <= state_d;
      elapsed_q <= elapsed_d;
      run_len_q <= run_len_d;
      half_q    <= half_d;
    end
  end

  // The final RUN edge clears the channels, so toggles landing on it never appear.
  assign tog_en  = (state_q == ST_RUN) && !finish;
  assign tog_clr = (state_q != ST_RUN) || finish;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    half_period_toggler #(.CNT_W(CNT_W)) u_tog (
      .clk   (clk),
      .reset (reset),
      .en    (tog_en),
      .clr   (tog_clr),
      .half  (half_q[c]),
      .q     (tog_q[c])
    );
  end

  assign sel  = tog_q[0];
  assign i0   = tog_q[1];
  assign i1   = tog_q[2];
  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_toggle_stim_gen.sv
// Self-checking bench for toggle_stim_gen against a cycle-index reference model.
module tb_toggle_stim_gen;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  half_sel, half_i0, half_i1;
  logic [15:0] run_len;
  logic        sel, i0, i1, busy, done;
  logic [4:0]  obs;
  logic [4:0]  exp_v;
  int          n_checks;
  int          n_pass;

  toggle_stim_gen #(.CNT_W(8), .RUN_W(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .half_sel (half_sel),
    .half_i0  (half_i0),
    .half_i1  (half_i1),
    .run_len  (run_len),
    .sel      (sel),
    .i0       (i0),
    .i1       (i1),
    .busy     (busy),
    .done     (done)
  );

  assign obs = {sel, i0, i1, busy, done};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Channel level t edges after launch: number of completed half-periods, mod 2.
  function automatic logic ch(input int t, input int h, input int l);
    if (h == 0 || t >= l) return 1'b0;
    return ((t / h) % 2) == 1;
  endfunction

  // {sel,i0,i1,busy,done} seen just after edge k+t for a run launched at edge k.
  function automatic logic [4:0] exp_vec(input int t, input int hs, input int h0,
                                         input int h1, input int l);
    return {ch(t, hs, l), ch(t, h0, l), ch(t, h1, l), t < l, t == l};
  endfunction

  // Present a launch while idle; returns #1 after the launch edge k.
  task automatic launch(input int hs, input int h0, input int h1, input int l);
    half_sel = 8'(hs);
    half_i0  = 8'(h0);
    half_i1  = 8'(h1);
    run_len  = 16'(l);
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1;
    half_sel = 8'd3; half_i0 = 8'd1; half_i1 = 8'd2; run_len = 16'd20;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (obs !== 5'b0) $display("FAIL reset_hold got %b expected %b", obs, 5'b0);
    else n_pass++;
    start = 1'b0; reset = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (obs !== 5'b0) $display("FAIL reset_release got %b expected %b", obs, 5'b0);
    else n_pass++;
  endtask

  task automatic test_basic();
    launch(75, 10, 55, 300);
    for (int t = 0; t <= 301; t++) begin
      if (t > 0) begin @(posedge clk); #1; end
      exp_v = exp_vec(t, 75, 10, 55, 300);
      n_checks++;
      if (obs !== exp_v) $display("FAIL basic t=%0d got %b expected %b", t, obs, exp_v);
      else n_pass++;
    end
  endtask

  task automatic test_fast();
    launch(0, 1, 0, 4);
    for (int t = 0; t <= 5; t++) begin
      if (t > 0) begin @(posedge clk); #1; end
      exp_v = exp_vec(t, 0, 1, 0, 4);
      n_checks++;
      if (obs !== exp_v) $display("FAIL fast t=%0d got %b expected %b", t, obs, exp_v);
      else n_pass++;
    end
  endtask

  task automatic test_zero_len();
    launch(5, 5, 5, 0);
    for (int t = 0; t <= 2; t++) begin
      if (t > 0) begin @(posedge clk); #1; end
      exp_v = exp_vec(t, 5, 5, 5, 0);
      n_checks++;
      if (obs !== exp_v) $display("FAIL zero_len t=%0d got %b expected %b", t, obs, exp_v);
      else n_pass++;
    end
  endtask

  task automatic test_reset_midrun();
    launch(0, 10, 0, 300);
    repeat (37) @(posedge clk);
    #1;
    exp_v = exp_vec(37, 0, 10, 0, 300);
    n_checks++;
    if (obs !== exp_v) $display("FAIL midrun_pre got %b expected %b", obs, exp_v);
    else n_pass++;
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (obs !== 5'b0) $display("FAIL midrun_async got %b expected %b", obs, 5'b0);
    else n_pass++;
    start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (obs !== 5'b0) $display("FAIL midrun_start_in_reset got %b expected %b", obs, 5'b0);
    else n_pass++;
    start = 1'b0; reset = 1'b0;
    @(posedge clk); #1;
    launch(4, 3, 0, 12);
    for (int t = 0; t <= 13; t++) begin
      if (t > 0) begin @(posedge clk); #1; end
      exp_v = exp_vec(t, 4, 3, 0, 12);
      n_checks++;
      if (obs !== exp_v) $display("FAIL relaunch t=%0d got %b expected %b", t, obs, exp_v);
      else n_pass++;
    end
  endtask

  task automatic test_restart_ignored();
    launch(0, 6, 9, 40);
    for (int t = 0; t <= 41; t++) begin
      if (t > 0) begin @(posedge clk); #1; end
      exp_v = exp_vec(t, 0, 6, 9, 40);
      n_checks++;
      if (obs !== exp_v) $display("FAIL restart t=%0d got %b expected %b", t, obs, exp_v);
      else n_pass++;
      if (t == 5)  start = 1'b1;
      if (t == 7)  start = 1'b0;
      if (t == 20) half_i0 = 8'd3;
      if (t == 22) run_len = 16'd5;
    end
  endtask

  task automatic test_back_to_back();
    half_sel = 8'd2; half_i0 = 8'd1; half_i1 = 8'd3; run_len = 16'd8;
    start = 1'b1;
    @(posedge clk); #1;
    for (int t = 0; t <= 19; t++) begin
      if (t > 0) begin @(posedge clk); #1; end
      if (t == 10) start = 1'b0;
      exp_v = (t <= 9) ? exp_vec(t, 2, 1, 3, 8) : exp_vec(t - 10, 2, 1, 3, 8);
      n_checks++;
      if (obs !== exp_v) $display("FAIL back_to_back t=%0d got %b expected %b", t, obs, exp_v);
      else n_pass++;
    end
  endtask

  task automatic test_boundary();
    launch(255, 254, 1, 520);
    for (int t = 0; t <= 521; t++) begin
      if (t > 0) begin @(posedge clk); #1; end
      exp_v = exp_vec(t, 255, 254, 1, 520);
      n_checks++;
      if (obs !== exp_v) $display("FAIL boundary_wide t=%0d got %b expected %b", t, obs, exp_v);
      else n_pass++;
    end
    launch(1, 1, 1, 1);
    for (int t = 0; t <= 2; t++) begin
      if (t > 0) begin @(posedge clk); #1; end
      exp_v = exp_vec(t, 1, 1, 1, 1);
      n_checks++;
      if (obs !== exp_v) $display("FAIL boundary_len1 t=%0d got %b expected %b", t, obs, exp_v);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      int hs, h0, h1, l;
      hs = int'($urandom_range(0, 9));
      h0 = int'($urandom_range(0, 9));
      h1 = int'($urandom_range(0, 9));
      l  = int'($urandom_range(0, 60));
      launch(hs, h0, h1, l);
      for (int t = 0; t <= l + 1; t++) begin
        if (t > 0) begin @(posedge clk); #1; end
        half_sel = 8'($urandom);
        half_i0  = 8'($urandom);
        exp_v = exp_vec(t, hs, h0, h1, l);
        n_checks++;
        if (obs !== exp_v)
          $display("FAIL random r=%0d h=%0d/%0d/%0d l=%0d t=%0d got %b expected %b",
                   r, hs, h0, h1, l, t, obs, exp_v);
        else n_pass++;
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b1;
    start    = 1'b0;
    half_sel = '0; half_i0 = '0; half_i1 = '0; run_len = '0;
    #1;
    test_reset();
    test_basic();
    test_fast();
    test_zero_len();
    test_reset_midrun();
    test_restart_ignored();
    test_back_to_back();
    test_boundary();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
